// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Rotates the active digit every REFRESH_DIV clocks and registers segment/anode pins together.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  nib,
  input  logic [7:0]  seg_in,
  output logic [7:0]  seg_out,
  output logic [3:0]  an,
  output logic        digit_tick
);

  localparam logic [23:0] CntMax = 24'(REFRESH_DIV - 1);

  logic [23:0] div_cnt_q, div_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shadow_val_q, shadow_val_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        tick_q, tick_d;
  logic        lead_zero;
  logic        blanked;

  always_comb begin
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    tick_d    = 1'b0;
    if (enable) begin
      if (div_cnt_q == CntMax) begin
        div_cnt_d = '0;
        idx_d     = idx_q + 2'd1;
        tick_d    = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 24'd1;
      end
    end
  end

  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
    end
  end

  assign nib = shadow_val_q[{idx_q, 2'b00} +: 4];

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    lead_zero = 1'b0;
    unique case (idx_q)
      2'd0: lead_zero = 1'b0;
      2'd1: lead_zero = (shadow_val_q[15:4] == 12'h000);
      2'd2: lead_zero = (shadow_val_q[15:8] == 8'h00);
      2'd3: lead_zero = (shadow_val_q[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
  end

  assign blanked = blank_lz & lead_zero;

  // Bit 7 of the decoder pattern is forced high, then the DP (active-low) is merged in.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 8'hFF;
    if (enable) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = (blanked ? 8'hFF : (seg_in | 8'h80)) & {~shadow_dp_q[idx_q], 7'h7F};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q    <= '0;
      idx_q        <= 2'd0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'b0000;
      an_q         <= 4'b1111;
      seg_q        <= 8'hFF;
      tick_q       <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      tick_q       <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg_out    = seg_q;
  assign digit_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: table-driven frames via a scoreboard queue,
// plus hand-written sequences for timing corner cases.
module tb_seg7_scan_driver;

  localparam int unsigned Div = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  nib;
  logic [7:0]  seg_in;
  logic [7:0]  seg_out;
  logic [3:0]  an;
  logic        digit_tick;
  logic [7:0]  dec;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(Div)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .nib        (nib),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an         (an),
    .digit_tick (digit_tick)
  );

  // Stand-in hex7seg decoder, active-low gfedcba.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  assign dec    = hex7(nib);
  assign seg_in = {~nib[0], dec[6:0]};  // junk on bit 7, which the DUT must ignore

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][7:0] exp;  // expected seg_out per digit, [d] = digit d
  } vec_t;

  typedef struct {
    int         id;
    int         dig;
    logic [3:0] an;
    logic [7:0] seg;
  } sb_t;

  vec_t vecs[6];
  sb_t  sb_q[$];
  logic sb_on = 1'b0;

  // Each digit_tick closes a slot; the pins still show the digit of that slot.
  always @(negedge clk) begin
    if (sb_on && digit_tick) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_extra_tick: got a tick with no expected frame pending");
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check($sformatf("scan_v%0d_d%0d", e.id, e.dig), {4'h0, an, seg_out}, {4'h0, e.an, e.seg});
      end
    end
  end

  task automatic fresh_start(input logic [15:0] v, input logic [3:0] d, input logic blz);
    reset  = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    value    = v;
    dp_in    = d;
    blank_lz = blz;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    logic [3:0] one;
    one      = 4'b0001;
    reset    = 1'b1;
    enable   = 1'b0;
    load     = 1'b0;
    value    = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{16'h00A0, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h88, 8'hC0}};
    vecs[2] = '{16'h00A0, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'h88, 8'hC0}};
    vecs[3] = '{16'h0000, 4'b0101, 1'b1, {8'hFF, 8'h7F, 8'hFF, 8'h40}};
    vecs[4] = '{16'h0F07, 4'b1000, 1'b1, {8'h7F, 8'h8E, 8'hC0, 8'hF8}};
    vecs[5] = '{16'hBEEF, 4'b1111, 1'b1, {8'h03, 8'h06, 8'h06, 8'h0E}};

    #1;
    check("reset_an", {12'h0, an}, 16'h000F);
    check("reset_seg", {8'h0, seg_out}, 16'h00FF);
    check("reset_tick", {15'h0, digit_tick}, 16'h0000);
    check("reset_nib", {12'h0, nib}, 16'h0000);
    @(negedge clk);

    // Scan order and tick cadence after enabling with 1234 already loaded.
    fresh_start(16'h1234, 4'b0000, 1'b0);
    enable = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      check($sformatf("scan_an_tick_%0d", n), {11'h0, an, digit_tick},
            {11'h0, ~(one << (((n - 1) / 4) % 4)), 1'(n % 4 == 0)});
      if (n == 1) begin
        check("first_seg", {8'h0, seg_out}, 16'h0099);
        check("first_nib", {12'h0, nib}, 16'h0004);
      end
    end

    // Load coincident with the idx 3 -> 0 advance.
    fresh_start(16'h1234, 4'b0000, 1'b0);
    enable = 1'b1;
    repeat (15) @(negedge clk);
    value = 16'hFFFF;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("coinc_nib", {12'h0, nib}, 16'h000F);
    check("coinc_tick", {15'h0, digit_tick}, 16'h0001);
    check("coinc_pins_old", {4'h0, an, seg_out}, {4'h0, 4'b0111, 8'hF9});
    @(negedge clk);
    check("coinc_pins_new", {4'h0, an, seg_out}, {4'h0, 4'b1110, 8'h8E});

    // Enable dropped with div_cnt = 2.
    fresh_start(16'h1234, 4'b0000, 1'b0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_pins", {3'h0, an, seg_out, digit_tick}, {3'h0, 4'hF, 8'hFF, 1'b0});
    repeat (4) @(negedge clk);
    check("dis_hold", {3'h0, nib, seg_out, digit_tick}, {3'h0, 4'h4, 8'hFF, 1'b0});
    enable = 1'b1;
    @(negedge clk);
    check("reen_1", {3'h0, an, seg_out, digit_tick}, {3'h0, 4'b1110, 8'h99, 1'b0});
    @(negedge clk);
    check("reen_2_tick", {15'h0, digit_tick}, 16'h0001);

    // Short asynchronous reset pulse between edges.
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_pins", {3'h0, an, seg_out, digit_tick}, {3'h0, 4'hF, 8'hFF, 1'b0});
    check("areset_nib", {12'h0, nib}, 16'h0000);
    #1 reset = 1'b0;
    @(negedge clk);
    check("areset_first", {4'h0, an, seg_out}, {4'h0, 4'b1110, 8'hC0});

    // Table-driven frames through the scoreboard.
    foreach (vecs[i]) begin
      reset    = 1'b1;
      enable   = 1'b1;
      value    = vecs[i].val;
      dp_in    = vecs[i].dp;
      blank_lz = vecs[i].blz;
      load     = 1'b1;
      for (int d = 0; d < 4; d++) begin
        sb_q.push_back('{i, d, ~(one << d), vecs[i].exp[d]});
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      load  = 1'b0;
      sb_on = 1'b1;
      for (int w = 0; w < 40 && sb_q.size() != 0; w++) @(negedge clk);
      sb_on = 1'b0;
      if (sb_q.size() != 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_timeout_v%0d: %0d frames still pending, required 0", i, sb_q.size());
        sb_q.delete();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
